monitor_host_link: RTL

Host-side initiator for the UART debug-monitor protocol. It serializes a one-byte command onto `tx_o`, then collects a fixed-length response (default 4 bytes) from `rx_i` and presents it as one 32-bit word. It is used for on-board self-test and loopback benches that drive the processor's system monitor from the FPGA fabric instead of a PC. The frame format is UART 8N1, LSB first, both directions.

---
 rtl/monitor_host_link.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/monitor_host_link.sv
// monitor_host_link: host-side initiator for the UART debug-monitor protocol.
// Sends one command byte (8N1, LSB first) on tx_o, then collects RESP_BYTES
// response bytes from rx_i and presents them as one 32-bit word.
// Optional response timeout: define MONITOR_HOST_TIMEOUT_EN to compile it in.
module monitor_host_link #(
    parameter int unsigned CLKS_PER_BIT   = 868,
    parameter int unsigned RESP_BYTES     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        clk_i,
    input  logic        rst_n,
    input  logic        cmd_valid_i,
    input  logic [7:0]  cmd_byte_i,
    output logic        cmd_ready_o,
    output logic        tx_o,
    input  logic        rx_i,
    output logic        resp_valid_o,
    output logic [31:0] resp_data_o,
    output logic        resp_err_o,
    output logic        busy_o
);

    localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [2:0]    LAST_BYTE = 3'(RESP_BYTES - 1);
    localparam logic [2:0]    BYTES_MAX = 3'(RESP_BYTES);

    // Elaboration-time parameter sanity checks
    if (CLKS_PER_BIT < 4) begin : g_bad_cpb
        $error("CLKS_PER_BIT must be at least 4");
    end
    if (RESP_BYTES < 1 || RESP_BYTES > 4) begin : g_bad_resp
        $error("RESP_BYTES must be in 1..4");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_to
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT_RESP
    } state_t;

    state_t          state_q;
    logic [7:0]      cmd_q;
    logic            tx_q;
    logic [CW-1:0]   clk_cnt_q;
    logic [3:0]      bit_q;
    logic            rx_s1_q;
    logic            rx_s2_q;
    logic            rx_prev_q;
    logic            rx_active_q;
    logic [7:0]      rx_byte_q;
    logic [2:0]      byte_idx_q;
    logic [31:0]     shadow_q;
    logic [31:0]     resp_data_q;
    logic            resp_valid_q;
    logic            resp_err_q;
    logic [31:0]     asm_word_d;
`ifdef MONITOR_HOST_TIMEOUT_EN
    localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);
    logic [31:0]     to_cnt_q;
`endif

    assign cmd_ready_o  = (state_q == IDLE);
    assign busy_o       = ~cmd_ready_o;
    assign tx_o         = tx_q;
    assign resp_valid_o = resp_valid_q;
    assign resp_err_o   = resp_err_q;
    assign resp_data_o  = resp_data_q;

    // Two-flop synchronizer for rx_i plus a delayed copy for falling-edge detection
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_s1_q   <= rx_i;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
        end
    end

    // Shadow word with the just-received byte merged into its slot
    always_comb begin
        asm_word_d = shadow_q;
        for (int unsigned i = 0; i < RESP_BYTES; i++) begin
            if (byte_idx_q == 3'(i)) begin
                asm_word_d[8*i +: 8] = rx_byte_q;
            end
        end
    end

    // Top FSM: command serializer, response deserializer and registered outputs
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cmd_q        <= '0;
            tx_q         <= 1'b1;
            clk_cnt_q    <= '0;
            bit_q        <= '0;
            rx_active_q  <= 1'b0;
            rx_byte_q    <= '0;
            byte_idx_q   <= '0;
            shadow_q     <= '0;
            resp_data_q  <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
`ifdef MONITOR_HOST_TIMEOUT_EN
            to_cnt_q     <= '0;
`endif
        end else begin
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cmd_valid_i) begin
                        cmd_q     <= cmd_byte_i;
                        tx_q      <= 1'b0;
                        clk_cnt_q <= '0;
                        bit_q     <= '0;
                        state_q   <= SEND;
                    end
                end

                SEND: begin
                    // bit_q: 0 = start, 1..8 = data, 9 = stop
                    if (clk_cnt_q == BIT_LAST) begin
                        clk_cnt_q <= '0;
                        if (bit_q == 4'd9) begin
                            tx_q        <= 1'b1;
                            bit_q       <= '0;
                            byte_idx_q  <= '0;
                            shadow_q    <= '0;
                            rx_active_q <= 1'b0;
`ifdef MONITOR_HOST_TIMEOUT_EN
                            to_cnt_q    <= '0;
`endif
                            state_q     <= WAIT_RESP;
                        end else begin
                            bit_q <= bit_q + 4'd1;
                            tx_q  <= (bit_q == 4'd8) ? 1'b1 : cmd_q[bit_q[2:0]];
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_q + 1'b1;
                    end
                end

                WAIT_RESP: begin
`ifdef MONITOR_HOST_TIMEOUT_EN
                    if (to_cnt_q == TO_LAST) begin
                        resp_err_q  <= 1'b1;
                        rx_active_q <= 1'b0;
                        state_q     <= IDLE;
                    end else begin
                        to_cnt_q <= to_cnt_q + 32'd1;
`else
                    begin
`endif
                        if (!rx_active_q) begin
                            if (rx_prev_q && !rx_s2_q) begin
                                rx_active_q <= 1'b1;
                                clk_cnt_q   <= '0;
                                bit_q       <= '0;
                            end
                        end else if (bit_q == 4'd0) begin
                            // Mid-start sample; a high line here was only a glitch
                            if (clk_cnt_q == HALF_LAST) begin
                                clk_cnt_q <= '0;
                                if (rx_s2_q) begin
                                    rx_active_q <= 1'b0;
                                end else begin
                                    bit_q <= 4'd1;
                                end
                            end else begin
                                clk_cnt_q <= clk_cnt_q + 1'b1;
                            end
                        end else if (clk_cnt_q == BIT_LAST) begin
                            clk_cnt_q <= '0;
                            if (bit_q == 4'd9) begin
                                rx_active_q <= 1'b0;
                                bit_q       <= '0;
                                if (!rx_s2_q) begin
                                    resp_err_q <= 1'b1;
                                    state_q    <= IDLE;
                                end else if (byte_idx_q == LAST_BYTE) begin
                                    resp_data_q  <= asm_word_d;
                                    resp_valid_q <= 1'b1;
                                    state_q      <= IDLE;
                                end else begin
                                    shadow_q <= asm_word_d;
                                    if (byte_idx_q != BYTES_MAX) begin
                                        byte_idx_q <= byte_idx_q + 3'd1;
                                    end
`ifdef MONITOR_HOST_TIMEOUT_EN
                                    to_cnt_q <= '0;
`endif
                                end
                            end else begin
                                rx_byte_q <= {rx_s2_q, rx_byte_q[7:1]};
                                bit_q     <= bit_q + 4'd1;
                            end
                        end else begin
                            clk_cnt_q <= clk_cnt_q + 1'b1;
                        end
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
